// File: rtl/ar_slice_otc.sv
// Registered AR-channel slice with a 2-entry skid buffer and per-master outstanding-read
// counters. The counters gate new requests and retire them on observed R-channel rlast beats.
module ar_slice_otc #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] araddr_in,
  input  logic [5:0]  arid_in,
  input  logic [1:0]  arburst_in,
  input  logic [3:0]  arlen_in,
  input  logic [2:0]  arsize_in,
  input  logic [1:0]  arlock_in,
  input  logic [3:0]  arcache_in,
  input  logic [2:0]  arprot_in,
  input  logic        arvalid_in,
  output logic        arready_in,
  output logic [31:0] araddr_s,
  output logic [5:0]  arid_s,
  output logic [1:0]  arburst_s,
  output logic [3:0]  arlen_s,
  output logic [2:0]  arsize_s,
  output logic [1:0]  arlock_s,
  output logic [3:0]  arcache_s,
  output logic [2:0]  arprot_s,
  output logic        arvalid_s,
  input  logic        arready_s,
  input  logic [5:0]  rid_s,
  input  logic        rlast_s,
  input  logic        rvalid_s,
  input  logic        rready_s,
  output logic [3:0]  otc_busy,
  output logic        err_underflow
);

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  id;
    logic [1:0]  burst;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } ar_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  ar_t             in_p;
  ar_t             main_q;
  ar_t             skid_q;
  logic            main_valid;
  logic            skid_valid;
  logic            acc_in;
  logic            acc_out;
  logic            ret;
  logic [1:0]      in_tag;
  logic [1:0]      ret_tag;
  logic [CNT_W-1:0] cnt     [4];
  logic [CNT_W-1:0] cnt_nxt [4];
  logic [3:0]      busy_nxt;
  logic            uf_nxt;
  logic            unused_rid;

  assign in_p = {araddr_in, arid_in, arburst_in, arlen_in,
                 arsize_in, arlock_in, arcache_in, arprot_in};
  assign {araddr_s, arid_s, arburst_s, arlen_s,
          arsize_s, arlock_s, arcache_s, arprot_s} = main_q;
  assign arvalid_s = main_valid;

  assign in_tag     = arid_in[5:4];
  assign ret_tag    = rid_s[5:4];
  assign unused_rid = ^rid_s[3:0];

  // Ready looks only at local registered state and the incoming tag, never at arready_s.
  assign arready_in = ~skid_valid & (cnt[in_tag] < MAX_C);
  assign acc_in     = arvalid_in & arready_in;
  assign acc_out    = main_valid & arready_s;
  assign ret        = rvalid_s & rready_s & rlast_s;

  // Skid can only be occupied while main is full, so a freed main slot always
  // takes the skid entry first; acc_in is blocked whenever skid is full.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (!main_valid || acc_out) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (acc_in) begin
        main_q     <= in_p;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (acc_in) begin
      skid_q     <= in_p;
      skid_valid <= 1'b1;
    end
  end

  always_comb begin
    uf_nxt   = err_underflow;
    busy_nxt = '0;
    for (int unsigned m = 0; m < 4; m++) begin
      cnt_nxt[m] = cnt[m];
      if (acc_in && in_tag == 2'(m) && !(ret && ret_tag == 2'(m))) begin
        cnt_nxt[m] = cnt[m] + CNT_W'(1);
      end else if (ret && ret_tag == 2'(m) && !(acc_in && in_tag == 2'(m))) begin
        if (cnt[m] == '0) begin
          uf_nxt = 1'b1;
        end else begin
          cnt_nxt[m] = cnt[m] - CNT_W'(1);
        end
      end
      busy_nxt[m] = (cnt_nxt[m] != '0);
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      for (int unsigned m = 0; m < 4; m++) begin
        cnt[m] <= '0;
      end
      otc_busy      <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int unsigned m = 0; m < 4; m++) begin
        cnt[m] <= cnt_nxt[m];
      end
      otc_busy      <= busy_nxt;
      err_underflow <= uf_nxt;
    end
  end

endmodule
